// File: rtl/int_issue_queue_if.sv
// Dispatch, CDB snoop and issue-port bundle of the integer reservation station.
// The queue takes the slave side; dispatch, the CDB and the integer unit share the master side.
interface int_issue_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 6
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             flush;
    logic             dispatch_en;
    logic [6:0]       disp_opcode;
    logic [2:0]       disp_funct3;
    logic [6:0]       disp_funct7;
    logic [XLEN-1:0]  disp_rs1_data;
    logic [TAG_W-1:0] disp_rs1_tag;
    logic             disp_rs1_rdy;
    logic [XLEN-1:0]  disp_rs2_data;
    logic [TAG_W-1:0] disp_rs2_tag;
    logic             disp_rs2_rdy;
    logic [TAG_W-1:0] disp_rd_tag;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_data;
    logic             queue_full;
    logic [CNT_W-1:0] entry_count;
    logic             issue_int;
    logic [6:0]       Opcode;
    logic [2:0]       Funct3;
    logic [6:0]       Funct7;
    logic [XLEN-1:0]  RS1;
    logic [XLEN-1:0]  RS2;
    logic [TAG_W-1:0] RD_Tag;

    modport master (
        output flush, dispatch_en, disp_opcode, disp_funct3, disp_funct7,
               disp_rs1_data, disp_rs1_tag, disp_rs1_rdy,
               disp_rs2_data, disp_rs2_tag, disp_rs2_rdy, disp_rd_tag,
               cdb_valid, cdb_tag, cdb_data,
        input  queue_full, entry_count, issue_int, Opcode, Funct3, Funct7,
               RS1, RS2, RD_Tag
    );

    modport slave (
        input  flush, dispatch_en, disp_opcode, disp_funct3, disp_funct7,
               disp_rs1_data, disp_rs1_tag, disp_rs1_rdy,
               disp_rs2_data, disp_rs2_tag, disp_rs2_rdy, disp_rd_tag,
               cdb_valid, cdb_tag, cdb_data,
        output queue_full, entry_count, issue_int, Opcode, Funct3, Funct7,
               RS1, RS2, RD_Tag
    );
endinterface

// File: rtl/int_issue_queue.sv
// Integer reservation station: buffers dispatched ops, wakes sources from the CDB,
// and issues the lowest-index operand-complete entry through registered outputs.
module int_issue_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    int_issue_queue_if.slave iq
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic             rdy;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } src_t;

    typedef struct packed {
        logic             valid;
        logic [6:0]       opcode;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [TAG_W-1:0] rd_tag;
        src_t             rs1;
        src_t             rs2;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    entry_t           new_ent;
    entry_t           sel_ent;
    logic             sel_vld;
    logic [IDX_W-1:0] sel_idx;
    logic             free_vld;
    logic [IDX_W-1:0] free_idx;
    logic             disp_ok;
    logic [CNT_W-1:0] count_d;
    logic             full_d;

    // A source captures the broadcast when it is still waiting on the matching tag.
    function automatic src_t snoop(input src_t s, input logic cv,
                                   input logic [TAG_W-1:0] ct, input logic [XLEN-1:0] cd);
        src_t r;
        r = s;
        if (cv && !s.rdy && (s.tag == ct)) begin
            r.rdy  = 1'b1;
            r.data = cd;
        end
        return r;
    endfunction

    // Oldest-slot-agnostic selection: lowest eligible index issues, lowest free index allocates.
    always_comb begin
        sel_vld  = 1'b0;
        sel_idx  = '0;
        sel_ent  = '0;
        free_vld = 1'b0;
        free_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!sel_vld && ent_q[i].valid && ent_q[i].rs1.rdy && ent_q[i].rs2.rdy) begin
                sel_vld = 1'b1;
                sel_idx = IDX_W'(i);
                sel_ent = ent_q[i];
            end
            if (!free_vld && !ent_q[i].valid) begin
                free_vld = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // Incoming entry, with same-cycle CDB bypass applied to its sources.
    always_comb begin
        new_ent          = '0;
        new_ent.valid    = 1'b1;
        new_ent.opcode   = iq.disp_opcode;
        new_ent.funct3   = iq.disp_funct3;
        new_ent.funct7   = iq.disp_funct7;
        new_ent.rd_tag   = iq.disp_rd_tag;
        new_ent.rs1.rdy  = iq.disp_rs1_rdy;
        new_ent.rs1.tag  = iq.disp_rs1_tag;
        new_ent.rs1.data = iq.disp_rs1_data;
        new_ent.rs2.rdy  = iq.disp_rs2_rdy;
        new_ent.rs2.tag  = iq.disp_rs2_tag;
        new_ent.rs2.data = iq.disp_rs2_data;
        new_ent.rs1      = snoop(new_ent.rs1, iq.cdb_valid, iq.cdb_tag, iq.cdb_data);
        new_ent.rs2      = snoop(new_ent.rs2, iq.cdb_valid, iq.cdb_tag, iq.cdb_data);
    end

    assign disp_ok = iq.dispatch_en && !iq.queue_full && !iq.flush && free_vld;

    // Next entry state: wakeup, issue-clear, allocation; flush overrides everything.
    always_comb begin
        count_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].valid) begin
                ent_d[i].rs1 = snoop(ent_q[i].rs1, iq.cdb_valid, iq.cdb_tag, iq.cdb_data);
                ent_d[i].rs2 = snoop(ent_q[i].rs2, iq.cdb_valid, iq.cdb_tag, iq.cdb_data);
            end
            if (sel_vld && (sel_idx == IDX_W'(i))) begin
                ent_d[i].valid = 1'b0;
            end
            if (disp_ok && (free_idx == IDX_W'(i))) begin
                ent_d[i] = new_ent;
            end
            if (iq.flush) begin
                ent_d[i].valid = 1'b0;
            end
            count_d = count_d + CNT_W'(ent_d[i].valid);
        end
        full_d = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            iq.entry_count <= '0;
            iq.queue_full  <= 1'b0;
        end else begin
            ent_q          <= ent_d;
            iq.entry_count <= count_d;
            iq.queue_full  <= full_d;
        end
    end

    // Issue register: payload holds when nothing is selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iq.issue_int <= 1'b0;
            iq.Opcode    <= '0;
            iq.Funct3    <= '0;
            iq.Funct7    <= '0;
            iq.RS1       <= '0;
            iq.RS2       <= '0;
            iq.RD_Tag    <= '0;
        end else if (iq.flush) begin
            iq.issue_int <= 1'b0;
        end else begin
            iq.issue_int <= sel_vld;
            if (sel_vld) begin
                iq.Opcode <= sel_ent.opcode;
                iq.Funct3 <= sel_ent.funct3;
                iq.Funct7 <= sel_ent.funct7;
                iq.RS1    <= sel_ent.rs1.data;
                iq.RS2    <= sel_ent.rs2.data;
                iq.RD_Tag <= sel_ent.rd_tag;
            end
        end
    end
endmodule

// File: tb/tb_int_issue_queue.sv
// Directed table-driven bench for int_issue_queue plus hand-written reset and wakeup sequences.
module tb_int_issue_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 6;
    localparam int          ADD   = 'h33;
    localparam int          OPI   = 'h13;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int_issue_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W)) iq_if ();

    int_issue_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .iq    (iq_if)
    );

    typedef struct {
        logic        disp;
        logic [6:0]  op;
        logic [5:0]  rd;
        logic        r1r;
        logic [5:0]  r1t;
        logic [31:0] r1d;
        logic        r2r;
        logic [5:0]  r2t;
        logic [31:0] r2d;
        logic        cv;
        logic [5:0]  ct;
        logic [31:0] cd;
        logic        fl;
        logic        e_iss;
        logic [6:0]  e_op;
        logic [5:0]  e_rd;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [2:0]  e_cnt;
        logic        e_full;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int disp, input int op, input int rd,
                                input int r1r, input int r1t, input int r1d,
                                input int r2r, input int r2t, input int r2d,
                                input int cv, input int ct, input int cd, input int fl,
                                input int ei, input int eop, input int erd,
                                input int e1, input int e2, input int ecnt, input int ef);
        vec_t v;
        v.disp = 1'(disp); v.op = 7'(op); v.rd = 6'(rd);
        v.r1r = 1'(r1r); v.r1t = 6'(r1t); v.r1d = 32'(r1d);
        v.r2r = 1'(r2r); v.r2t = 6'(r2t); v.r2d = 32'(r2d);
        v.cv = 1'(cv); v.ct = 6'(ct); v.cd = 32'(cd); v.fl = 1'(fl);
        v.e_iss = 1'(ei); v.e_op = 7'(eop); v.e_rd = 6'(erd);
        v.e_rs1 = 32'(e1); v.e_rs2 = 32'(e2); v.e_cnt = 3'(ecnt); v.e_full = 1'(ef);
        return v;
    endfunction

    function automatic vec_t idle(input int cv, input int ct, input int cd, input int fl,
                                  input int ei, input int eop, input int erd,
                                  input int e1, input int e2, input int ecnt, input int ef);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, cv, ct, cd, fl, ei, eop, erd, e1, e2, ecnt, ef);
    endfunction

    task automatic drive(input vec_t v);
        iq_if.dispatch_en   = v.disp;
        iq_if.disp_opcode   = v.op;
        iq_if.disp_funct3   = v.rd[2:0];
        iq_if.disp_funct7   = {1'b0, v.rd};
        iq_if.disp_rd_tag   = v.rd;
        iq_if.disp_rs1_rdy  = v.r1r;
        iq_if.disp_rs1_tag  = v.r1t;
        iq_if.disp_rs1_data = v.r1d;
        iq_if.disp_rs2_rdy  = v.r2r;
        iq_if.disp_rs2_tag  = v.r2t;
        iq_if.disp_rs2_data = v.r2d;
        iq_if.cdb_valid     = v.cv;
        iq_if.cdb_tag       = v.ct;
        iq_if.cdb_data      = v.cd;
        iq_if.flush         = v.fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_payload(input string tag, input logic [6:0] op, input logic [5:0] rd,
                               input logic [31:0] r1, input logic [31:0] r2);
        chk({tag, ".Opcode"}, 32'(iq_if.Opcode), 32'(op));
        chk({tag, ".Funct3"}, 32'(iq_if.Funct3), 32'(rd[2:0]));
        chk({tag, ".Funct7"}, 32'(iq_if.Funct7), 32'({1'b0, rd}));
        chk({tag, ".RS1"}, iq_if.RS1, r1);
        chk({tag, ".RS2"}, iq_if.RS2, r2);
        chk({tag, ".RD_Tag"}, 32'(iq_if.RD_Tag), 32'(rd));
    endtask

    initial begin
        vec_t nop;
        int   lat;

        nop = idle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        drive(nop);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.issue_int", 32'(iq_if.issue_int), 0);
        chk("rst.entry_count", 32'(iq_if.entry_count), 0);
        chk("rst.queue_full", 32'(iq_if.queue_full), 0);
        chk_payload("rst", 7'd0, 6'd0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Reset sanity: ready ADD issues one edge after dispatch.
        vecs.push_back(mk(1, ADD, 3, 1, 0, 5, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(idle(0, 0, 0, 0, 1, ADD, 3, 5, 7, 0, 0));
        vecs.push_back(idle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Wakeup via CDB tag 9.
        vecs.push_back(mk(1, OPI, 10, 0, 9, 0, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(idle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(idle(1, 9, 100, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(idle(0, 0, 0, 0, 1, OPI, 10, 100, 4, 0, 0));
        vecs.push_back(idle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Dispatch-time bypass.
        vecs.push_back(mk(1, ADD, 11, 1, 0, 1, 0, 12, 0, 1, 12, 'hDEAD, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(idle(0, 0, 0, 0, 1, ADD, 11, 1, 'hDEAD, 0, 0));
        vecs.push_back(idle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Fill on tag 20, refuse a fifth, then drain in index order.
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(1, ADD, 21 + k, 0, 20, 0, 1, 0, 'h11 + k, 0, 0, 0, 0,
                              0, 0, 0, 0, 0, k + 1, (k == 3) ? 1 : 0));
        vecs.push_back(mk(1, ADD, 30, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 1));
        vecs.push_back(idle(1, 20, 'h77, 0, 0, 0, 0, 0, 0, 4, 1));
        for (int k = 0; k < 4; k++)
            vecs.push_back(idle(0, 0, 0, 0, 1, ADD, 21 + k, 'h77, 'h11 + k, 3 - k, 0));
        vecs.push_back(idle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Out-of-order issue.
        vecs.push_back(mk(1, OPI, 40, 0, 5, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, ADD, 41, 1, 0, 8, 1, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));
        vecs.push_back(idle(0, 0, 0, 0, 1, ADD, 41, 8, 9, 1, 0));
        vecs.push_back(idle(1, 5, 55, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(idle(0, 0, 0, 0, 1, OPI, 40, 55, 2, 0, 0));
        vecs.push_back(idle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Flush with pending dispatch; old tags must not resurrect anything.
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1, ADD, 50 + k, 0, 50 + k, 0, 1, 0, 3, 0, 0, 0, 0,
                              0, 0, 0, 0, 0, k + 1, 0));
        vecs.push_back(mk(1, ADD, 53, 0, 53, 0, 1, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(idle(1, 50 + k, 'h500 + k, 0, 0, 0, 0, 0, 0, 0, 0));
        // Flush beats an eligible issue.
        vecs.push_back(mk(1, ADD, 60, 1, 0, 6, 1, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(idle(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(idle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Issue and dispatch on the same edge.
        vecs.push_back(mk(1, ADD, 61, 1, 0, 1, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, OPI, 62, 1, 0, 3, 1, 0, 4, 0, 0, 0, 0, 1, ADD, 61, 1, 2, 1, 0));
        vecs.push_back(idle(0, 0, 0, 0, 1, OPI, 62, 3, 4, 0, 0));
        // Tag 0 is ordinary; a matching tag with cdb_valid=0 must not wake.
        vecs.push_back(mk(1, ADD, 2, 0, 0, 0, 1, 0, 5, 0, 0, 'h99, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(idle(0, 0, 'h99, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(idle(1, 0, 'h42, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(idle(0, 0, 0, 0, 1, ADD, 2, 'h42, 5, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            step();
            chk($sformatf("v%0d.issue_int", i), 32'(iq_if.issue_int), 32'(vecs[i].e_iss));
            chk($sformatf("v%0d.entry_count", i), 32'(iq_if.entry_count), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d.queue_full", i), 32'(iq_if.queue_full), 32'(vecs[i].e_full));
            if (vecs[i].e_iss)
                chk_payload($sformatf("v%0d", i), vecs[i].e_op, vecs[i].e_rd,
                            vecs[i].e_rs1, vecs[i].e_rs2);
        end
        drive(nop);

        // Both sources wake on one broadcast; issue must appear on the first edge after it.
        drive(mk(1, OPI, 63, 0, 7, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        drive(idle(1, 7, 'h33, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        drive(nop);
        chk("wake2.no_early_issue", 32'(iq_if.issue_int), 0);
        lat = 99;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (iq_if.issue_int && lat == 99) begin
                lat = c;
                chk_payload("wake2", 7'(OPI), 6'd63, 32'h33, 32'h33);
            end
        end
        chk("wake2.latency", 32'(lat), 1);

        // Asynchronous reset mid-operation discards the queue and the issue register.
        drive(mk(1, ADD, 31, 0, 30, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        drive(mk(1, ADD, 32, 1, 0, 'hA, 1, 0, 'hB, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        drive(nop);
        step();
        chk("prerst.issue_int", 32'(iq_if.issue_int), 1);
        chk("prerst.entry_count", 32'(iq_if.entry_count), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst.issue_int", 32'(iq_if.issue_int), 0);
        chk("midrst.entry_count", 32'(iq_if.entry_count), 0);
        chk_payload("midrst", 7'd0, 6'd0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(mk(1, ADD, 33, 1, 0, 'hC, 1, 0, 'hD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        drive(nop);
        chk("postrst.edge1_issue", 32'(iq_if.issue_int), 0);
        chk("postrst.edge1_count", 32'(iq_if.entry_count), 1);
        step();
        chk("postrst.edge2_issue", 32'(iq_if.issue_int), 1);
        chk_payload("postrst", 7'(ADD), 6'd33, 32'hC, 32'hD);
        drive(idle(1, 30, 'h30, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        drive(nop);
        step();
        chk("postrst.lost_tag_issue", 32'(iq_if.issue_int), 0);
        chk("postrst.lost_tag_count", 32'(iq_if.entry_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
